com_rx: RTL

- Receive-side packet decoder for the com link; the opposite end of the tx framer that the com controller drives.
- Takes a byte stream from the PHY/UART layer, finds frame sync and parses header, length and payload.
- Writes payload bytes into the shared packet RAM and checks an 8-bit additive checksum.
- Reports the result to the com controller through the fs_rx/fd_rx handshake, with the packet type on rx_btype (4-bit BAG_* encoding).

---
 rtl/com_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/com_rx.sv
// com_rx: receive-side packet decoder for the com link.
// Finds SYNC0/SYNC1, parses the type/length header, writes the payload into the
// packet RAM, checks an 8-bit additive checksum and reports to the controller.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rx_data, rx_valid  incoming byte stream (one-cycle strobe per byte)
//   rx_ram_init        payload base address, sampled on SYNC0 in IDLE
//   fs_rx / fd_rx      packet-ready level / controller-taken level
//   rx_btype, rx_dlen  decoded type (4'hF on any failure) and payload length
//   ram_wen/waddr/wdata payload write port
//   rx_drop            pulse for a byte discarded in DONE/DACK
module com_rx #(
  parameter logic [7:0]  TIMEOUT = 8'h80,
  parameter logic [11:0] MAXLEN  = 12'h800,
  parameter logic [7:0]  SYNC0   = 8'hEB,
  parameter logic [7:0]  SYNC1   = 8'h90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [11:0] rx_ram_init,
  output logic        fs_rx,
  input  logic        fd_rx,
  output logic [3:0]  rx_btype,
  output logic [11:0] rx_dlen,
  output logic        ram_wen,
  output logic [11:0] ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic        rx_drop
);

  localparam logic [3:0] BAG_INIT  = 4'b0000;
  localparam logic [3:0] BAG_ERROR = 4'b1111;

  typedef enum logic [2:0] {IDLE, SYNC, HEAD0, HEAD1, DATA, CHK, DONE, DACK} state_t;

  state_t      state, state_d;
  logic [11:0] base, base_d;
  logic [11:0] cnt, cnt_d;
  logic [11:0] dlen, dlen_d;
  logic [3:0]  btype, btype_d;
  logic [7:0]  sum, sum_d;
  logic [7:0]  tcnt, tcnt_d;
  logic        fs_d, wen_d, drop_d;
  logic [3:0]  rx_btype_d;
  logic [11:0] rx_dlen_d, waddr_d;
  logic [7:0]  wdata_d;
  logic        in_frame, tmo;
  logic [11:0] len_full;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      cnt       <= '0;
      dlen      <= '0;
      btype     <= '0;
      sum       <= '0;
      tcnt      <= '0;
      fs_rx     <= 1'b0;
      rx_btype  <= BAG_INIT;
      rx_dlen   <= '0;
      ram_wen   <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
      rx_drop   <= 1'b0;
    end else begin
      state     <= state_d;
      base      <= base_d;
      cnt       <= cnt_d;
      dlen      <= dlen_d;
      btype     <= btype_d;
      sum       <= sum_d;
      tcnt      <= tcnt_d;
      fs_rx     <= fs_d;
      rx_btype  <= rx_btype_d;
      rx_dlen   <= rx_dlen_d;
      ram_wen   <= wen_d;
      ram_waddr <= waddr_d;
      ram_wdata <= wdata_d;
      rx_drop   <= drop_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    base_d     = base;
    cnt_d      = cnt;
    dlen_d     = dlen;
    btype_d    = btype;
    sum_d      = sum;
    tcnt_d     = tcnt;
    rx_btype_d = rx_btype;
    rx_dlen_d  = rx_dlen;
    wen_d      = 1'b0;
    waddr_d    = ram_waddr;
    wdata_d    = ram_wdata;
    drop_d     = 1'b0;
    len_full   = {dlen[11:8], rx_data};

    // Idle-gap counter: a byte always clears it, even on the limit cycle
    in_frame = (state == SYNC) || (state == HEAD0) || (state == HEAD1) ||
               (state == DATA) || (state == CHK);
    tmo      = in_frame && !rx_valid && (tcnt == 8'(TIMEOUT - 8'd1));
    if (in_frame) begin
      if (rx_valid)  tcnt_d = '0;
      else if (!tmo) tcnt_d = 8'(tcnt + 8'd1);
    end

    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SYNC0) begin
          state_d    = SYNC;
          base_d     = rx_ram_init;
          sum_d      = '0;
          cnt_d      = '0;
          tcnt_d     = '0;
          rx_btype_d = BAG_INIT;
          rx_dlen_d  = '0;
        end
      end
      SYNC: begin
        if (rx_valid) begin
          if (rx_data == SYNC1)      state_d = HEAD0;
          else if (rx_data != SYNC0) state_d = IDLE;
        end
      end
      HEAD0: begin
        if (rx_valid) begin
          btype_d = rx_data[7:4];
          dlen_d  = {rx_data[3:0], 8'h00};
          sum_d   = 8'(sum + rx_data);
          state_d = HEAD1;
        end
      end
      HEAD1: begin
        if (rx_valid) begin
          dlen_d    = len_full;
          rx_dlen_d = len_full;
          sum_d     = 8'(sum + rx_data);
          if (len_full > MAXLEN) begin
            rx_btype_d = BAG_ERROR;
            state_d    = DONE;
          end else if (len_full == 12'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          wen_d   = 1'b1;
          waddr_d = 12'(base + cnt);
          wdata_d = rx_data;
          sum_d   = 8'(sum + rx_data);
          cnt_d   = 12'(cnt + 12'd1);
          if (cnt == 12'(dlen - 12'd1)) state_d = CHK;
        end
      end
      CHK: begin
        if (rx_valid) begin
          rx_btype_d = (rx_data == sum) ? btype : BAG_ERROR;
          state_d    = DONE;
        end
      end
      DONE: begin
        drop_d = rx_valid;
        if (fd_rx) state_d = DACK;
      end
      DACK: begin
        drop_d = rx_valid;
        if (!fd_rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Gap expiry: silent in SYNC, reported as an error once the header started
    if (tmo) begin
      if (state == SYNC) begin
        state_d = IDLE;
      end else begin
        state_d    = DONE;
        rx_btype_d = BAG_ERROR;
      end
    end

    fs_d = (state_d == DONE);
  end

endmodule
